// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and defaults for the shift-register sequencer.
//   sr_state_t  : sequencer FSM state encoding
//   SR_W_DEF    : default shift register width
//   SR_DIV_DEF  : default shift-tick divider
//   cnt_width() : width of a down-counter that must hold n-1
package shift_seq_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} sr_state_t;

   localparam int SR_W_DEF   = 8;
   localparam int SR_DIV_DEF = 4;

   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Parallel-side bundle of the shift-register sequencer.
//   load_valid_i / load_ready_o / load_data_i : word-in handshake
//   rx_valid_o / rx_data_o                    : received-word strobe and data
// Modports: master = producer/consumer side, slave = sequencer side.
interface shift_seq_ctrl_if
   import shift_seq_pkg::*;
#(
   parameter int W = SR_W_DEF
) ();

   logic          load_valid_i;
   logic          load_ready_o;
   logic [W-1:0]  load_data_i;
   logic          rx_valid_o;
   logic [W-1:0]  rx_data_o;

   modport master (
      output load_valid_i,
      output load_data_i,
      input  load_ready_o,
      input  rx_valid_o,
      input  rx_data_o
   );

   modport slave (
      input  load_valid_i,
      input  load_data_i,
      output load_ready_o,
      output rx_valid_o,
      output rx_data_o
   );

endinterface

// File: rtl/shift_seq_ctrl_tick_gen.sv
// Shift-tick divider, only built when SR_CLKDIV_EN is defined.
//   clk, rst : clock, async active-low reset
//   clr      : restart the divider at 0 (new transfer)
//   run      : count only while the sequencer is shifting
//   tick     : high on the last cycle of each DIV-cycle period
`ifdef SR_CLKDIV_EN
module shift_tick_gen
   import shift_seq_pkg::*;
#(
   parameter int DIV = SR_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int CW = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   // With DIV=1 the counter never leaves 0, so tick follows run every cycle.
   assign tick = run && (cnt == LAST);

endmodule
`endif

// File: rtl/shift_seq_ctrl.sv
// Full-duplex shift-register sequencer.
// Takes a W-bit word over a valid/ready handshake, shifts it out MSB-first on
// ser_o while shifting ser_i in at the LSB, then presents the received word
// with a one-cycle rx_valid_o pulse.
//   clk, rst      : clock, async active-low reset
//   bus (slave)   : load handshake + received word (shift_seq_ctrl_if)
//   ser_i / ser_o : serial in / out (ser_o = shift register MSB)
//   shift_en_o    : strobe on every shift tick
//   busy_o        : transfer in progress (SHIFT or DONE)
// Build option SR_CLKDIV_EN: shift ticks come from a DIV-cycle divider
// instead of every cycle.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int W   = SR_W_DEF,
   parameter int DIV = SR_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   shift_seq_ctrl_if.slave  bus,
   input  logic             ser_i,
   output logic             ser_o,
   output logic             shift_en_o,
   output logic             busy_o
);

   // state    | meaning
   // ST_IDLE  | waiting for a word, load_ready_o high
   // ST_SHIFT | shifting one bit per tick, cnt counts W-1..0
   // ST_DONE  | one cycle, rx_valid_o pulse with the received word

   localparam int CW = cnt_width(W);

   if (W < 2) begin : g_bad_w
      $error("shift_seq_ctrl: W must be >= 2");
   end
   if (DIV < 1) begin : g_bad_div
      $error("shift_seq_ctrl: DIV must be >= 1");
   end

   sr_state_t      state;
   logic [W-1:0]   sr;
   logic [CW-1:0]  cnt;
   logic           ready_q;
   logic           busy_q;
   logic           rx_valid_q;
   logic [W-1:0]   rx_data_q;
   logic           in_shift;
   logic           accept;
   logic           tick;

   assign in_shift = (state == ST_SHIFT);
   assign accept   = (state == ST_IDLE) && ready_q && bus.load_valid_i;

`ifdef SR_CLKDIV_EN
   shift_tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .run  (in_shift),
      .tick (tick)
   );
`else
   assign tick = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         sr         <= '0;
         cnt        <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               // ready comes up one cycle after reset release and stays up
               // until a word is taken
               ready_q <= 1'b1;
               if (accept) begin
                  sr      <= bus.load_data_i;
                  cnt     <= CW'(W - 1);
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (tick) begin
                  sr <= {sr[W-2:0], ser_i};
                  if (cnt == '0) begin
                     // capture the post-shift value so rx_data_o is valid
                     // in the same cycle as the rx_valid_o pulse
                     rx_data_q  <= {sr[W-2:0], ser_i};
                     rx_valid_q <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign ser_o            = sr[W-1];
   assign shift_en_o       = in_shift && tick;
   assign busy_o           = busy_q;
   assign bus.load_ready_o = ready_q;
   assign bus.rx_valid_o   = rx_valid_q;
   assign bus.rx_data_o    = rx_data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
   import shift_seq_pkg::*;

   localparam int W   = 8;
   localparam int DIV = 4;
`ifdef SR_CLKDIV_EN
   localparam int TICK = DIV;
`else
   localparam int TICK = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ser_i = 1'b0;
   logic ser_o, shift_en_o, busy_o;

   shift_seq_ctrl_if #(.W(W)) bus_if ();

   shift_seq_ctrl #(.W(W), .DIV(DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if),
      .ser_i      (ser_i),
      .ser_o      (ser_o),
      .shift_en_o (shift_en_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] prev_rx = '0;

   typedef struct {
      logic [W-1:0] data;
      bit           loop;
      logic [W-1:0] pat;
      logic [W-1:0] exp_rx;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Present a word and wait (bounded) for the handshake; on return we are
   // at the negedge of cycle 1 (first cycle after the handshake edge).
   task automatic start_word(input logic [W-1:0] data, output bit ok);
      ok = 1'b0;
      bus_if.load_valid_i = 1'b1;
      bus_if.load_data_i  = data;
      for (int i = 0; i < 60; i++) begin
         if (bus_if.load_ready_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("handshake_wait", {31'b0, ok}, 32'd1);
      if (ok) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic run_word(input vec_t v, input bit hold_next, input logic [W-1:0] next_data);
      bit ok;
      bit tk;
      int k;
      int nsh;
      int nrx;
      int last;
      logic [3:0] exp_f;
      k = 0; nsh = 0; nrx = 0;
      last = W*TICK + 2;
      start_word(v.data, ok);
      if (!ok) return;
      if (hold_next) begin
         bus_if.load_data_i = next_data;
      end else begin
         bus_if.load_valid_i = 1'b0;
         bus_if.load_data_i  = ~v.data;
      end
      for (int cyc = 1; cyc <= last; cyc++) begin
         if (cyc > 1) @(negedge clk);
         tk = (cyc <= W*TICK) && (cyc % TICK == 0);
         exp_f = {cyc == last, cyc < last, tk, cyc == W*TICK + 1};
         check($sformatf("flags_%0h_c%0d", v.data, cyc),
               {28'b0, bus_if.load_ready_o, busy_o, shift_en_o, bus_if.rx_valid_o}, {28'b0, exp_f});
         if (shift_en_o) nsh++;
         if (bus_if.rx_valid_o) nrx++;
         if (tk) begin
            check($sformatf("ser_o_%0h_b%0d", v.data, k), {31'b0, ser_o}, {31'b0, v.data[W-1-k]});
            ser_i = v.loop ? ser_o : v.pat[W-1-k];
            k++;
         end else begin
            ser_i = 1'($urandom_range(0, 1));
         end
         if (cyc == W*TICK)
            check($sformatf("rx_hold_%0h", v.data), {24'b0, bus_if.rx_data_o}, {24'b0, prev_rx});
         if (cyc == W*TICK + 1)
            check($sformatf("rx_data_%0h", v.data), {24'b0, bus_if.rx_data_o}, {24'b0, v.exp_rx});
      end
      check($sformatf("n_shift_%0h", v.data), nsh, W);
      check($sformatf("n_rx_%0h", v.data), nrx, 1);
      prev_rx = v.exp_rx;
   endtask

   initial begin
      bit ok;
      int n;
      vec_t v;

      vecs[0] = '{data: 8'hA5, loop: 1'b1, pat: 8'h00, exp_rx: 8'hA5};
      vecs[1] = '{data: 8'h00, loop: 1'b0, pat: 8'hFF, exp_rx: 8'hFF};
      vecs[2] = '{data: 8'hFF, loop: 1'b0, pat: 8'h00, exp_rx: 8'h00};
      vecs[3] = '{data: 8'h81, loop: 1'b0, pat: 8'h6E, exp_rx: 8'h6E};
      vecs[4] = '{data: 8'h3C, loop: 1'b1, pat: 8'h00, exp_rx: 8'h3C};

      bus_if.load_valid_i = 1'b0;
      bus_if.load_data_i  = '0;

      // reset state
      #1;
      check("reset_outputs", {27'b0, bus_if.load_ready_o, busy_o, shift_en_o, bus_if.rx_valid_o, ser_o}, 32'd0);
      check("reset_rx_data", {24'b0, bus_if.rx_data_o}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {30'b0, bus_if.load_ready_o, busy_o}, 32'b10);

      // directed word table
      for (int i = 0; i < 5; i++) run_word(vecs[i], 1'b0, '0);

      // load held during a transfer must wait for the cycle after DONE
      v = '{data: 8'h96, loop: 1'b1, pat: 8'h00, exp_rx: 8'h96};
      run_word(v, 1'b1, 8'h3C);
      run_word(vecs[4], 1'b0, '0);

      // abort: reset after the third shift
      start_word(8'h96, ok);
      bus_if.load_valid_i = 1'b0;
      n = 0;
      for (int cyc = 1; cyc <= W*TICK + 2 && n < 3; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (shift_en_o) begin
            n++;
            ser_i = ser_o;
         end
      end
      check("abort_shift_count", n, 3);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_outputs", {27'b0, bus_if.load_ready_o, busy_o, shift_en_o, bus_if.rx_valid_o, ser_o}, 32'd0);
      check("abort_rx_data", {24'b0, bus_if.rx_data_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("abort_quiet_%0d", i), {30'b0, bus_if.rx_valid_o, busy_o}, 32'd0);
      end
      rst = 1'b1;
      prev_rx = '0;
      v = '{data: 8'h5A, loop: 1'b1, pat: 8'h00, exp_rx: 8'h5A};
      run_word(v, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
